cdc_hs_bus: RTL

- Parametrised clock-domain-crossing handshake for a multi-bit word, moving one word at a time from clk1 to clk2.
- Valid/ready on both sides: source backpressure replaces the single-pulse-in / pulse-out interface of the older block.
- Selectable 4-phase (level) or 2-phase (toggle) req/ack protocol, with a configurable synchroniser depth.
- Sits between any clk1 producer and clk2 consumer for low-rate control or config words.

---
 rtl/cdc_pkg.sv | 20 ++
 rtl/cdc_sync_bit.sv | 26 ++
 rtl/cdc_hs_bus.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
`timescale 1ns/1ps
// Shared protocol constants and FSM state types for the clk1->clk2 handshake bus.
package cdc_pkg;

  localparam int unsigned MODE_4PH = 0;
  localparam int unsigned MODE_2PH = 1;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_REQ  = 2'd1,
    SRC_DROP = 2'd2
  } src_state_e;

  typedef enum logic [1:0] {
    DST_WAIT = 2'd0,
    DST_HOLD = 2'd1,
    DST_ACK  = 2'd2
  } dst_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
`timescale 1ns/1ps
// Multi-flop single-bit synchroniser, async reset to 0.
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_bus.sv
`timescale 1ns/1ps
// Valid/ready word transfer from clk1 to clk2 over a req/ack handshake;
// MODE selects 4-phase level or 2-phase toggle signalling.
module cdc_hs_bus
  import cdc_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = MODE_4PH
) (
  input  logic          clk1,
  input  logic          rst1_n,
  input  logic          clk2,
  input  logic          rst2_n,
  input  logic          src_vld,
  input  logic [DW-1:0] src_dat,
  output logic          src_rdy,
  output logic          src_done,
  output logic          busy,
  output logic          dst_vld,
  output logic [DW-1:0] dst_dat,
  input  logic          dst_rdy
);

  localparam logic TOGGLE = (MODE == MODE_2PH);

  // clk1 domain state
  src_state_e    src_state_q, src_state_d;
  logic          req_q, req_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          src_rdy_q, src_rdy_d;
  logic          busy_q, busy_d;
  logic          src_done_q, src_done_d;
  logic          ack_sync;

  // clk2 domain state
  dst_state_e    dst_state_q, dst_state_d;
  logic          ack_q, ack_d;
  logic          dst_vld_q, dst_vld_d;
  logic [DW-1:0] dst_dat_q, dst_dat_d;
  logic          req_hist_q;
  logic          req_sync;
  logic          req_event_c;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk_i   (clk2),
    .rst_n_i (rst2_n),
    .d_i     (req_q),
    .q_o     (req_sync)
  );

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i   (clk1),
    .rst_n_i (rst1_n),
    .d_i     (ack_q),
    .q_o     (ack_sync)
  );

  // Source FSM: capture on accept, hold the word until the ack round trip closes.
  always_comb begin
    src_state_d = src_state_q;
    req_d       = req_q;
    hold_d      = hold_q;
    src_done_d  = 1'b0;
    unique case (src_state_q)
      SRC_IDLE: begin
        if (src_vld) begin
          hold_d      = src_dat;
          req_d       = TOGGLE ? ~req_q : 1'b1;
          src_state_d = SRC_REQ;
        end
      end
      SRC_REQ: begin
        if (TOGGLE) begin
          if (ack_sync == req_q) begin
            src_state_d = SRC_IDLE;
            src_done_d  = 1'b1;
          end
        end else if (ack_sync) begin
          req_d       = 1'b0;
          src_state_d = SRC_DROP;
        end
      end
      SRC_DROP: begin
        if (!ack_sync) begin
          src_state_d = SRC_IDLE;
          src_done_d  = 1'b1;
        end
      end
      default: src_state_d = SRC_IDLE;
    endcase
    src_rdy_d = (src_state_d == SRC_IDLE);
    busy_d    = ~src_rdy_d;
  end

  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      src_state_q <= SRC_IDLE;
      req_q       <= 1'b0;
      hold_q      <= '0;
      src_rdy_q   <= 1'b1;
      busy_q      <= 1'b0;
      src_done_q  <= 1'b0;
    end else begin
      src_state_q <= src_state_d;
      req_q       <= req_d;
      hold_q      <= hold_d;
      src_rdy_q   <= src_rdy_d;
      busy_q      <= busy_d;
      src_done_q  <= src_done_d;
    end
  end

  // 4-phase reacts to the rising level only; 2-phase to any transition.
  assign req_event_c = TOGGLE ? (req_sync ^ req_hist_q) : (req_sync & ~req_hist_q);

  // Destination FSM: present the word, then return ack once the consumer takes it.
  always_comb begin
    dst_state_d = dst_state_q;
    ack_d       = ack_q;
    dst_vld_d   = dst_vld_q;
    dst_dat_d   = dst_dat_q;
    unique case (dst_state_q)
      DST_WAIT: begin
        if (req_event_c) begin
          dst_dat_d   = hold_q;
          dst_vld_d   = 1'b1;
          dst_state_d = DST_HOLD;
        end
      end
      DST_HOLD: begin
        if (dst_vld_q && dst_rdy) begin
          dst_vld_d = 1'b0;
          if (TOGGLE) begin
            ack_d       = req_sync;
            dst_state_d = DST_WAIT;
          end else begin
            ack_d       = 1'b1;
            dst_state_d = DST_ACK;
          end
        end
      end
      DST_ACK: begin
        if (!req_sync) begin
          ack_d       = 1'b0;
          dst_state_d = DST_WAIT;
        end
      end
      default: dst_state_d = DST_WAIT;
    endcase
  end

  always_ff @(posedge clk2 or negedge rst2_n) begin
    if (!rst2_n) begin
      dst_state_q <= DST_WAIT;
      ack_q       <= 1'b0;
      dst_vld_q   <= 1'b0;
      dst_dat_q   <= '0;
      req_hist_q  <= 1'b0;
    end else begin
      dst_state_q <= dst_state_d;
      ack_q       <= ack_d;
      dst_vld_q   <= dst_vld_d;
      dst_dat_q   <= dst_dat_d;
      req_hist_q  <= req_sync;
    end
  end

  assign src_rdy  = src_rdy_q;
  assign busy     = busy_q;
  assign src_done = src_done_q;
  assign dst_vld  = dst_vld_q;
  assign dst_dat  = dst_dat_q;

endmodule
